// File: rtl/rx_seg_display.sv
// rx_seg_display
//
// Pops ASCII bytes from the UART receive buffer, interprets hex digits
// ('0'-'9', 'A'-'F', 'a'-'f') and keeps the last four of them in a 16-bit
// display register. That register is shown on a 4-digit, time-multiplexed,
// common-anode 7-segment display.
//
// Control bytes:
//   ESC (0x1B)          clears the display register
//   CR (0x0D), LF (0x0A) are ignored silently
//   anything else        leaves the register alone and pulses bad_char
//
// Configuration macro:
//   SEG_BLANK_EN  defined   -> leading-zero blanking on digits 3..1
//                 undefined -> all four digits always shown
//
// Parameters:
//   REFRESH_DIV   clk cycles per digit slot (2 .. 2**20)
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   rx_data  [7:0]   head byte of the receiver buffer, valid when rx_empty = 0
//   rx_empty         receiver buffer empty
//   forward_rx_data  one-cycle pop strobe to the receiver
//   seg      [6:0]   segments {g,f,e,d,c,b,a}, active low
//   an       [3:0]   digit enables, active low, an[0] = rightmost digit
//   dp               decimal point, active low, always off
//   bad_char         one-cycle pulse for an unrecognised byte
//   disp_val [15:0]  display register (debug / verification)

module rx_seg_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_empty,
   output logic        forward_rx_data,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic        bad_char,
   output logic [15:0] disp_val
);

   localparam int               CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

`ifdef SEG_BLANK_EN
   localparam logic BLANK_EN = 1'b1;
`else
   localparam logic BLANK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Segment pattern for one hex nibble, bit 6 = g, active low.
   function automatic logic [6:0] font(input logic [3:0] n);
      logic [6:0] f;
      case (n)
         4'h0:    f = 7'h40;
         4'h1:    f = 7'h79;
         4'h2:    f = 7'h24;
         4'h3:    f = 7'h30;
         4'h4:    f = 7'h19;
         4'h5:    f = 7'h12;
         4'h6:    f = 7'h02;
         4'h7:    f = 7'h78;
         4'h8:    f = 7'h00;
         4'h9:    f = 7'h10;
         4'hA:    f = 7'h08;
         4'hB:    f = 7'h03;
         4'hC:    f = 7'h46;
         4'hD:    f = 7'h21;
         4'hE:    f = 7'h06;
         4'hF:    f = 7'h0E;
         default: f = 7'h7F;
      endcase
      return f;
   endfunction

   // Returns {is_hex, nibble}. Letters map via their low nibble (A/a = 1) + 9.
   function automatic logic [4:0] hex_nibble(input logic [7:0] b);
      logic [4:0] r;
      if ((b >= 8'h30) && (b <= 8'h39)) begin
         r = {1'b1, b[3:0]};
      end else if (((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66))) begin
         r = {1'b1, b[3:0] + 4'd9};
      end else begin
         r = 5'd0;
      end
      return r;
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic             fwd_r;
   logic [7:0]       byte_r;
   logic [15:0]      disp_val_r;
   logic [15:0]      disp_nxt_s;
   logic             bad_r;
   logic             bad_nxt_s;
   logic [4:0]       hex_s;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       idx_r;
   logic [3:0]       digit_s;
   logic             blank_s;
   logic [6:0]       seg_nxt_s;
   logic [6:0]       seg_r;
   logic [3:0]       an_r;

   // Pop FSM next state and byte decode (decode only acts in GAP).
   always_comb begin
      state_nxt_s = state_r;
      disp_nxt_s  = disp_val_r;
      bad_nxt_s   = 1'b0;
      hex_s       = hex_nibble(byte_r);
      case (state_r)
         ST_IDLE: begin
            if (!rx_empty) begin
               state_nxt_s = ST_POP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_POP: begin
            state_nxt_s = ST_GAP;
         end
         ST_GAP: begin
            // GAP gives the receiver one cycle to refresh rx_empty.
            state_nxt_s = ST_IDLE;
            if (hex_s[4]) begin
               disp_nxt_s = {disp_val_r[11:0], hex_s[3:0]};
            end else if (byte_r == 8'h1B) begin
               disp_nxt_s = 16'h0000;
            end else if ((byte_r == 8'h0D) || (byte_r == 8'h0A)) begin
               disp_nxt_s = disp_val_r;
            end else begin
               bad_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Pop FSM state, pop strobe, latched byte, display register, error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         fwd_r      <= 1'b0;
         byte_r     <= 8'h00;
         disp_val_r <= 16'h0000;
         bad_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         // Strobe is high exactly while the FSM sits in POP.
         fwd_r      <= (state_nxt_s == ST_POP);
         if (state_r == ST_POP) begin
            byte_r <= rx_data;
         end
         disp_val_r <= disp_nxt_s;
         bad_r      <= bad_nxt_s;
      end
   end

   // Refresh timing: cnt wraps at REFRESH_DIV-1 and advances the digit slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         idx_r <= 2'd0;
      end else if (cnt_r == CNT_MAX) begin
         cnt_r <= '0;
         idx_r <= idx_r + 2'd1;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Select the nibble for the current slot and whether it is a leading zero.
   always_comb begin
      digit_s = 4'h0;
      blank_s = 1'b0;
      case (idx_r)
         2'd0: begin
            digit_s = disp_val_r[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            digit_s = disp_val_r[7:4];
            blank_s = (disp_val_r[15:4] == 12'h000);
         end
         2'd2: begin
            digit_s = disp_val_r[11:8];
            blank_s = (disp_val_r[15:8] == 8'h00);
         end
         2'd3: begin
            digit_s = disp_val_r[15:12];
            blank_s = (disp_val_r[15:12] == 4'h0);
         end
         default: begin
            digit_s = 4'h0;
            blank_s = 1'b0;
         end
      endcase
      if (BLANK_EN && blank_s) begin
         seg_nxt_s = 7'h7F;
      end else begin
         seg_nxt_s = font(digit_s);
      end
   end

   // Display output registers, refreshed every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r  <= 4'hF;
         seg_r <= 7'h7F;
      end else begin
         an_r  <= ~(4'b0001 << idx_r);
         seg_r <= seg_nxt_s;
      end
   end

   assign forward_rx_data = fwd_r;
   assign seg             = seg_r;
   assign an              = an_r;
   assign dp              = 1'b1;
   assign bad_char        = bad_r;
   assign disp_val        = disp_val_r;

endmodule

// File: tb/tb_rx_seg_display.sv
`timescale 1ns/1ps

module tb_rx_seg_display;

   localparam int REFRESH_DIV = 4;
   localparam int TMO         = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_empty = 1'b1;
   logic        forward_rx_data;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        bad_char;
   logic [15:0] disp_val;

   logic [7:0]  rx_fifo [$];
   logic [16:0] exp_q [$];     // {bad_char, disp_val} expected after each decode
   int          pop_t_q [$];
   int          errors = 0;
   int          checks = 0;
   int          cycle = 0;

   rx_seg_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_data         (rx_data),
      .rx_empty        (rx_empty),
      .forward_rx_data (forward_rx_data),
      .seg             (seg),
      .an              (an),
      .dp              (dp),
      .bad_char        (bad_char),
      .disp_val        (disp_val)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic [15:0] exp_disp, input logic exp_bad);
      rx_fifo.push_back(b);
      exp_q.push_back({exp_bad, exp_disp});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (((rx_fifo.size() != 0) || (exp_q.size() != 0)) && (n < TMO)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= TMO) begin
         errors++;
         $display("FAIL %s: timeout with %0d bytes and %0d results pending", name, rx_fifo.size(), exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic check_refresh(input string name, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an [4];
      int n;
      exp_seg = '{s0, s1, s2, s3};
      exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
      n = 0;
      while ((an !== 4'h7) && (n < 40)) begin
         @(negedge clk);
         n++;
      end
      while ((an !== 4'hE) && (n < 40)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL %s_sync: an stuck at %0h", name, an);
      end
      for (int k = 0; k < 4; k++) begin
         chk({name, "_an"}, 32'(an), 32'(exp_an[k]));
         chk({name, "_seg"}, 32'(seg), 32'(exp_seg[k]));
         repeat (REFRESH_DIV) @(negedge clk);
      end
   endtask

   // Receiver model plus scoreboard monitor, all on the falling edge.
   initial begin : monitor
      logic [1:0]  hist;
      logic        pop_pending;
      logic [16:0] e;
      logic [7:0]  junk;
      int          last_pop;
      hist        = 2'b00;
      pop_pending = 1'b0;
      last_pop    = -10;
      forever begin
         @(negedge clk);
         cycle++;
         // Decode result for the pop seen two falling edges ago.
         if (rst) begin
            hist = 2'b00;
         end else if (hist[1]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_decode: disp_val %0h with no expectation", disp_val);
            end else begin
               e = exp_q.pop_front();
               chk("disp_val", 32'(disp_val), 32'(e[15:0]));
               chk("bad_char", 32'(bad_char), 32'(e[16]));
            end
         end
         hist = {hist[0], (forward_rx_data && !rst)};
         if (forward_rx_data) begin
            checks++;
            if (rx_empty || ((cycle - last_pop) < 3)) begin
               errors++;
               $display("FAIL pop_protocol: empty=%0d spacing=%0d required >=3 and not empty", rx_empty, cycle - last_pop);
            end
            last_pop = cycle;
            pop_t_q.push_back(cycle);
         end
         if (pop_pending && (rx_fifo.size() > 0)) begin
            junk = rx_fifo.pop_front();
         end
         pop_pending = forward_rx_data;
         rx_empty    = (rx_fifo.size() == 0);
         rx_data     = rx_empty ? 8'h00 : rx_fifo[0];
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      int pops;
      // Reset held with a byte waiting.
      rst = 1'b1;
      send(8'h30, 16'h0000, 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk("rst_fwd", 32'(forward_rx_data), 32'd0);
         chk("rst_an", 32'(an), 32'hF);
         chk("rst_seg", 32'(seg), 32'h7F);
         chk("rst_disp", 32'(disp_val), 32'd0);
      end
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_bad", 32'(bad_char), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_an", 32'(an), 32'hE);
      chk("first_seg", 32'(seg), 32'h40);
      drain("reset_byte");

      // "12aF"
      pop_t_q.delete();
      send(8'h31, 16'h0001, 1'b0);
      send(8'h32, 16'h0012, 1'b0);
      send(8'h61, 16'h012A, 1'b0);
      send(8'h46, 16'h12AF, 1'b0);
      drain("12aF");
      chk("pops_12aF", 32'(pop_t_q.size()), 32'd4);
      check_refresh("refresh_12AF", 7'h0E, 7'h08, 7'h24, 7'h79);

      // Fifth digit, then ESC.
      send(8'h37, 16'h2AF7, 1'b0);
      send(8'h1B, 16'h0000, 1'b0);
      drain("digit5_esc");

      // Bad and ignored bytes, plus range boundaries.
      send(8'h47, 16'h0000, 1'b1);
      send(8'h0D, 16'h0000, 1'b0);
      send(8'h0A, 16'h0000, 1'b0);
      send(8'h39, 16'h0009, 1'b0);
      send(8'h66, 16'h009F, 1'b0);
      send(8'h30, 16'h09F0, 1'b0);
      send(8'h2F, 16'h09F0, 1'b1);
      send(8'h3A, 16'h09F0, 1'b1);
      send(8'h40, 16'h09F0, 1'b1);
      send(8'h60, 16'h09F0, 1'b1);
      send(8'h67, 16'h09F0, 1'b1);
      send(8'h41, 16'h9F0A, 1'b0);
      send(8'h1B, 16'h0000, 1'b0);
      drain("bad_bytes");

      // Back-to-back bytes: pops exactly 3 cycles apart.
      pop_t_q.delete();
      send(8'h33, 16'h0003, 1'b0);
      send(8'h34, 16'h0034, 1'b0);
      send(8'h35, 16'h0345, 1'b0);
      send(8'h36, 16'h3456, 1'b0);
      drain("3456");
      chk("pops_3456", 32'(pop_t_q.size()), 32'd4);
      if (pop_t_q.size() == 4) begin
         for (int i = 0; i < 3; i++) begin
            chk("pop_spacing", 32'(pop_t_q[i+1] - pop_t_q[i]), 32'd3);
         end
      end

      // Reset in the GAP cycle after the second pop.
      pop_t_q.delete();
      send(8'h31, 16'h4561, 1'b0);
      rx_fifo.push_back(8'h32);
      rx_fifo.push_back(8'h33);
      rx_fifo.push_back(8'h34);
      n = 0;
      pops = 0;
      while ((pops < 2) && (n < TMO)) begin
         @(negedge clk);
         n++;
         if (forward_rx_data) begin
            pops++;
         end
      end
      chk("mid_rst_pops_seen", 32'(pops), 32'd2);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_fwd", 32'(forward_rx_data), 32'd0);
         chk("mid_rst_disp", 32'(disp_val), 32'd0);
      end
      rx_fifo.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_disp", 32'(disp_val), 32'd0);
      chk("post_rst_pops", 32'(pop_t_q.size()), 32'd2);
      chk("post_rst_pending", 32'(exp_q.size()), 32'd0);

      // Leading-zero display.
      send(8'h1B, 16'h0000, 1'b0);
      send(8'h35, 16'h0005, 1'b0);
      drain("blank");
`ifdef SEG_BLANK_EN
      check_refresh("refresh_0005", 7'h12, 7'h7F, 7'h7F, 7'h7F);
`else
      check_refresh("refresh_0005", 7'h12, 7'h40, 7'h40, 7'h40);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
